if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the five-stage pipeline: owns the PC, issues word reads to instruction memory over a request/acknowledge handshake, and drives the instruction word and PC+4 that the IF/ID pipeline register captures. It sits between the instruction memory and the IF/ID register. It honours downstream stall and branch/jump redirects from decode, and it inserts bubbles while memory has not yet answered.

## Interface
- RESET_PC, 30'h0000_0C00, word address fetched first after reset (byte address 0x0000_3000).
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- stall  in  1  IF/ID not accepting; hold outputs.
- branch_taken  in  1  redirect to branch_target this cycle.
- branch_target  in  [31:2]  word address.
- jump  in  1  redirect to jump_target this cycle.
- jump_target  in  [31:2]  word address, fully formed by decode.
- imem_req  out  1  read request.
- imem_addr  out  [31:2]  request word address.
- imem_ack  in  1  read data valid; may arrive in the same cycle as imem_req or later.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- ins  out  32  instruction to IF/ID.
- PC_plus_4  out  [31:2]  fetched word address + 1.
- if_valid  out  1  ins/PC_plus_4 carry a real instruction; 0 = bubble (ins = NOP 32'h0).

## Operation
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the outstanding request.
  - buf_ins, buf_pc4: one-entry holding buffer.
  - state: REQ, KILL or BUF.
- Redirect = branch_taken | jump. Target priority: branch_target over jump_target.
- REQ:
  - imem_req=1, imem_addr=req_addr.
  - On ack with no redirect and output free (!stall): the output registers load imem_rdata and req_addr+1, with if_valid=1. Then pc and req_addr advance by 1; stay in REQ.
  - On ack with stall: the word goes to buf. pc advances. Go to BUF.
  - No ack, no redirect: hold. The request stays asserted with the address unchanged. If !stall, the outputs load a bubble.
- BUF:
  - imem_req=0.
  - When !stall: outputs load from buf. req_addr=pc. Go to REQ.
- KILL:
  - imem_req=1, imem_addr=req_addr (the old address; the address never changes mid-request).
  - On ack: data is discarded, req_addr=pc (the redirect target). Go to REQ.
- Redirect, in any state, regardless of stall:
  - Outputs load a bubble (ins=0, if_valid=0, PC_plus_4 held).
  - pc=target.
  - Any buffered word is dropped.
  - If a request is outstanding without ack this cycle: go to KILL.
  - Otherwise (ack this cycle, discarded; or BUF): req_addr=target, go to REQ.
- Redirect wins over stall and over a same-cycle ack.
- Arithmetic: all +1 increments are on 30-bit word addresses and wrap modulo 2^30 (3FFF_FFFF+1 → 0).
- Reset:
  - pc=req_addr=RESET_PC, state=REQ.
  - ins=0, PC_plus_4=0, if_valid=0, buf cleared.
  - imem_req is forced to 0 while Reset is high.
  - Instruction memory shares Reset, so an outstanding request is abandoned, not completed.

## Timing
- Zero-wait memory (ack in the same cycle as req), no stall: the word requested in cycle n appears on ins/if_valid in cycle n+1. Throughput is one instruction per cycle.
- Memory with k wait cycles: k bubbles per instruction.
- Stall freezes ins/PC_plus_4/if_valid on the same edge. At most one word is fetched during a stall.
- Redirect in cycle n:
  - Bubble on outputs at n+1.
  - If no request was outstanding, the target is requested at n+1 and its word appears at n+2 earliest.
  - From KILL, the first target request starts the cycle after the old ack.

## Structure
- Shared pipeline package:
  - fetch state enum (REQ, KILL, BUF).
  - NOP constant 32'h0000_0000.
  - default RESET_PC value.
- No sub-module is needed. The next-pc/target select stays inline with the FSM in one always block plus a combinational output block.

## Test plan
- Reset, zero-wait memory returning rdata=addr: after Reset drops, ins = 0x3000>>2, 0xC01, 0xC02… on consecutive cycles. PC_plus_4 = 0xC01, 0xC02…, if_valid=1.
- Memory with 2 wait cycles: imem_addr is stable for 3 cycles per word. Two bubbles (if_valid=0, ins=0) separate valid words.
- stall high for 3 cycles mid-stream: outputs frozen; exactly one extra request is issued; after release, buffered word 0xC05 then 0xC06 follow with no loss or duplication.
- branch_taken and jump both high in the same cycle, branch_target=0x100, jump_target=0x200: one bubble, then ins from 0x100 and PC_plus_4=0x101.
- Redirect to 0x40 while a request to 0xC03 waits for ack: imem_addr stays 0xC03 until ack, its data never reaches ins, then 0x40 is requested.
- req_addr=0x3FFF_FFFF: the next request address is 0x0000_0000 and PC_plus_4 for that word is 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage: fetch FSM states,
// the NOP encoding and the default reset fetch address.
package if_fetch_pkg;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_KILL = 2'd1,
      ST_BUF  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP              = 32'h0000_0000;
   localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;

   function automatic logic [29:0] inc_word(input logic [29:0] addr);
      return addr + 30'd1;
   endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives word requests to instruction memory
// and presents the fetched word and PC+4 (word address + 1) to the IF/ID register.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [29:0] branch_target_i,
   input  logic        jump_i,
   input  logic [29:0] jump_target_i,
   output logic        imem_req_o,
   output logic [29:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] ins_o,
   output logic [29:0] pc_plus_4_o,
   output logic        if_valid_o
);

   fetch_state_e state_q;
   logic [29:0]  pc_q;
   logic [29:0]  req_addr_q;
   logic [31:0]  buf_ins_q;
   logic [29:0]  buf_pc4_q;
   logic [31:0]  ins_q;
   logic [29:0]  pc4_q;
   logic         valid_q;

   logic         redirect;
   logic [29:0]  target;
   logic [29:0]  req_addr_inc;

   always_comb begin
      redirect     = branch_taken_i | jump_i;
      target       = branch_taken_i ? branch_target_i : jump_target_i;
      req_addr_inc = inc_word(req_addr_q);
      // The memory shares reset, so the request is withheld while reset is high.
      imem_req_o   = !reset_i && ((state_q == ST_REQ) || (state_q == ST_KILL));
      imem_addr_o  = req_addr_q;
      ins_o        = ins_q;
      pc_plus_4_o  = pc4_q;
      if_valid_o   = valid_q;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_REQ;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         buf_ins_q  <= NOP;
         buf_pc4_q  <= 30'd0;
         ins_q      <= NOP;
         pc4_q      <= 30'd0;
         valid_q    <= 1'b0;
      end else if (redirect) begin
         // Redirect beats stall and any same-cycle ack; an unanswered request must drain first.
         ins_q     <= NOP;
         valid_q   <= 1'b0;
         pc_q      <= target;
         buf_ins_q <= NOP;
         buf_pc4_q <= 30'd0;
         if (state_q != ST_BUF && !imem_ack_i) begin
            state_q <= ST_KILL;
         end else begin
            req_addr_q <= target;
            state_q    <= ST_REQ;
         end
      end else begin
         case (state_q)
            ST_REQ: begin
               if (imem_ack_i && !stall_i) begin
                  ins_q      <= imem_rdata_i;
                  pc4_q      <= req_addr_inc;
                  valid_q    <= 1'b1;
                  pc_q       <= req_addr_inc;
                  req_addr_q <= req_addr_inc;
               end else if (imem_ack_i) begin
                  buf_ins_q <= imem_rdata_i;
                  buf_pc4_q <= req_addr_inc;
                  pc_q      <= req_addr_inc;
                  state_q   <= ST_BUF;
               end else if (!stall_i) begin
                  ins_q   <= NOP;
                  valid_q <= 1'b0;
               end
            end
            ST_BUF: begin
               if (!stall_i) begin
                  ins_q      <= buf_ins_q;
                  pc4_q      <= buf_pc4_q;
                  valid_q    <= 1'b1;
                  req_addr_q <= pc_q;
                  state_q    <= ST_REQ;
               end
            end
            ST_KILL: begin
               if (!stall_i) begin
                  ins_q   <= NOP;
                  valid_q <= 1'b0;
               end
               if (imem_ack_i) begin
                  req_addr_q <= pc_q;
                  state_q    <= ST_REQ;
               end
            end
            default: begin
               state_q <= ST_REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a memory model answering rdata = word address with a
// programmable number of wait cycles, plus hand-computed expected outputs per cycle.
module tb_if_fetch;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [29:0] branch_target;
   logic        jump;
   logic [29:0] jump_target;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ins;
   logic [29:0] pc_plus_4;
   logic        if_valid;

   logic [3:0]  wait_cycles;
   logic [3:0]  wcnt;
   logic        mem_hold;

   int checks;
   int errors;

   if_fetch dut (
      .clk_i           (clk),
      .reset_i         (reset),
      .stall_i         (stall),
      .branch_taken_i  (branch_taken),
      .branch_target_i (branch_target),
      .jump_i          (jump),
      .jump_target_i   (jump_target),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_ack_i      (imem_ack),
      .imem_rdata_i    (imem_rdata),
      .ins_o           (ins),
      .pc_plus_4_o     (pc_plus_4),
      .if_valid_o      (if_valid)
   );

   always #5 clk = ~clk;

   assign imem_ack   = imem_req && !mem_hold && (wcnt >= wait_cycles);
   assign imem_rdata = {2'b00, imem_addr};

   always @(posedge clk) begin
      if (reset || !imem_req || imem_ack) wcnt <= 4'd0;
      else                                wcnt <= wcnt + 4'd1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [31:0] e_ins,
                            input logic [29:0] e_pc4, input logic e_valid);
      check({tag, "_ins"}, ins, e_ins);
      check({tag, "_pc4"}, {2'b00, pc_plus_4}, {2'b00, e_pc4});
      check({tag, "_valid"}, {31'd0, if_valid}, {31'd0, e_valid});
   endtask

   task automatic check_req(input string tag, input logic e_req, input logic [29:0] e_addr);
      check({tag, "_req"}, {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) check({tag, "_addr"}, {2'b00, imem_addr}, {2'b00, e_addr});
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      clk           = 1'b0;
      reset         = 1'b1;
      stall         = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 30'd0;
      jump          = 1'b0;
      jump_target   = 30'd0;
      wait_cycles   = 4'd0;
      mem_hold      = 1'b0;

      repeat (3) step();
      check_out("reset", 32'h0, 30'h0, 1'b0);
      check_req("reset", 1'b0, 30'h0);

      reset = 1'b0;
      #1;
      check_req("first_req", 1'b1, 30'h0000_0C00);

      // Zero-wait stream: one instruction per cycle.
      for (int i = 0; i < 5; i++) begin
         step();
         check_out("stream", 32'h0000_0C00 + 32'(i), 30'h0000_0C01 + 30'(i), 1'b1);
      end
      check_req("stream_next", 1'b1, 30'h0000_0C05);

      // Three stall cycles: one extra fetch into the buffer, outputs frozen.
      stall = 1'b1;
      step();
      check_out("stall1", 32'h0000_0C04, 30'h0000_0C05, 1'b1);
      check_req("stall1", 1'b0, 30'h0);
      step();
      check_out("stall2", 32'h0000_0C04, 30'h0000_0C05, 1'b1);
      check_req("stall2", 1'b0, 30'h0);
      step();
      check_out("stall3", 32'h0000_0C04, 30'h0000_0C05, 1'b1);
      check_req("stall3", 1'b0, 30'h0);
      stall = 1'b0;
      step();
      check_out("unstall_buf", 32'h0000_0C05, 30'h0000_0C06, 1'b1);
      check_req("unstall_buf", 1'b1, 30'h0000_0C06);
      step();
      check_out("unstall_next", 32'h0000_0C06, 30'h0000_0C07, 1'b1);
      check_req("unstall_next", 1'b1, 30'h0000_0C07);

      // Two wait cycles per word.
      wait_cycles = 4'd2;
      step();
      check_out("wait_b1", 32'h0, 30'h0000_0C07, 1'b0);
      check_req("wait_b1", 1'b1, 30'h0000_0C07);
      step();
      check_out("wait_b2", 32'h0, 30'h0000_0C07, 1'b0);
      check_req("wait_b2", 1'b1, 30'h0000_0C07);
      step();
      check_out("wait_w1", 32'h0000_0C07, 30'h0000_0C08, 1'b1);
      check_req("wait_w1", 1'b1, 30'h0000_0C08);
      step();
      check_out("wait_b3", 32'h0, 30'h0000_0C08, 1'b0);
      step();
      check_out("wait_b4", 32'h0, 30'h0000_0C08, 1'b0);
      step();
      check_out("wait_w2", 32'h0000_0C08, 30'h0000_0C09, 1'b1);
      check_req("wait_w2", 1'b1, 30'h0000_0C09);
      wait_cycles = 4'd0;
      step();
      check_out("nowait", 32'h0000_0C09, 30'h0000_0C0A, 1'b1);

      // Branch and jump together: branch target wins.
      branch_taken  = 1'b1;
      jump          = 1'b1;
      branch_target = 30'h0000_0100;
      jump_target   = 30'h0000_0200;
      step();
      check_out("dual_bubble", 32'h0, 30'h0000_0C0A, 1'b0);
      check_req("dual_bubble", 1'b1, 30'h0000_0100);
      branch_taken = 1'b0;
      jump         = 1'b0;
      step();
      check_out("dual_target", 32'h0000_0100, 30'h0000_0101, 1'b1);

      // Redirect while a request to 0xC03 is waiting for its ack.
      jump        = 1'b1;
      jump_target = 30'h0000_0C03;
      step();
      check_req("kill_setup", 1'b1, 30'h0000_0C03);
      jump     = 1'b0;
      mem_hold = 1'b1;
      step();
      check_req("kill_wait", 1'b1, 30'h0000_0C03);
      branch_taken  = 1'b1;
      branch_target = 30'h0000_0040;
      step();
      check_req("kill_held1", 1'b1, 30'h0000_0C03);
      check_out("kill_held1", 32'h0, 30'h0000_0101, 1'b0);
      branch_taken = 1'b0;
      step();
      check_req("kill_held2", 1'b1, 30'h0000_0C03);
      mem_hold = 1'b0;
      step();
      check_out("kill_drop", 32'h0, 30'h0000_0101, 1'b0);
      check_req("kill_target", 1'b1, 30'h0000_0040);
      step();
      check_out("kill_word", 32'h0000_0040, 30'h0000_0041, 1'b1);

      // Word address wrap.
      jump        = 1'b1;
      jump_target = 30'h3FFF_FFFF;
      step();
      check_req("wrap_req", 1'b1, 30'h3FFF_FFFF);
      jump = 1'b0;
      step();
      check_out("wrap_top", 32'h3FFF_FFFF, 30'h0000_0000, 1'b1);
      check_req("wrap_next", 1'b1, 30'h0000_0000);
      step();
      check_out("wrap_zero", 32'h0000_0000, 30'h0000_0001, 1'b1);

      // Reset abandons an outstanding request.
      mem_hold = 1'b1;
      step();
      reset = 1'b1;
      #1;
      check_req("reset_mid", 1'b0, 30'h0);
      step();
      check_out("reset_mid", 32'h0, 30'h0, 1'b0);
      reset    = 1'b0;
      mem_hold = 1'b0;
      #1;
      check_req("reset_restart", 1'b1, 30'h0000_0C00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
